// File: rtl/serv_vpu_issue_q.sv
// ---------------------------------------------------------------------------
// serv_vpu_issue_q
//
// Issue queue between the SERV core's extension/VPU interface and the vector
// execution backend. It captures each vector or FP load/store command that the
// core presents, acknowledges it with a one-cycle o_ext_ready pulse, and holds
// it in a DEPTH-entry FIFO. This lets the bit-serial core run ahead of the
// backend. Vector-config ops (vsetvl*, OP-V with funct3=3'b111) are also
// queued. Their acknowledge waits for the backend's scalar result (the new vl),
// and that result is returned on o_ext_rd.
//
// Optional feature (macro VPU_ISSUE_PERF_EN):
//   Adds the 32-bit wrapping counters o_perf_issued (one per enqueue) and
//   o_perf_full_stall (one per IDLE cycle in which the core waits on a full
//   FIFO). When the macro is undefined, neither the ports nor the counters
//   exist.
//
// Parameters:
//   DEPTH  FIFO entries, a power of two and >= 2
//   PTR_W  pointer width, derived from DEPTH
//
// Ports:
//   clk, i_rst_n        clock; asynchronous active-low reset
//   i_vpu_valid         core command request, held until o_ext_ready
//   i_vector_op,
//   i_load_fp_op,
//   i_store_fp_op       op class
//   i_funct3, i_funct6,
//   i_vm, i_mop,
//   i_vd, i_vs1, i_vs2  decoded instruction fields
//   i_rs1, i_rs2        scalar operand values
//   o_ext_ready         single-cycle accept/complete pulse to the core
//   o_ext_rd            scalar result (non-zero only for config ops, only
//                       while o_ext_ready=1)
//   o_cmd_valid/
//   i_cmd_ready/
//   o_cmd_data          FIFO head handshake to the backend; the packed layout
//                       is {rs2,rs1,vs2,vs1,vd,mop,vm,funct6,funct3,store,load}
//                       with load at bit 0
//   i_res_valid/
//   i_res_data          backend scalar result for config ops
//   o_busy              FIFO non-empty or handshake FSM not idle
// ---------------------------------------------------------------------------
module serv_vpu_issue_q #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_vpu_valid,
    input  logic        i_vector_op,
    input  logic        i_load_fp_op,
    input  logic        i_store_fp_op,
    input  logic [2:0]  i_funct3,
    input  logic [5:0]  i_funct6,
    input  logic        i_vm,
    input  logic [1:0]  i_mop,
    input  logic [4:0]  i_vd,
    input  logic [4:0]  i_vs1,
    input  logic [4:0]  i_vs2,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_ext_ready,
    output logic [31:0] o_ext_rd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [92:0] o_cmd_data,
    input  logic        i_res_valid,
    input  logic [31:0] i_res_data,
    output logic        o_busy
`ifdef VPU_ISSUE_PERF_EN
    ,
    output logic [31:0] o_perf_issued,
    output logic [31:0] o_perf_full_stall
`endif
);

    localparam int              CMD_W    = 93;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RES = 2'd1,
        RESP     = 2'd2,
        GUARD    = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [CMD_W-1:0]   mem [DEPTH];

    logic               is_cfg;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [CMD_W-1:0]   cmd_in;

    logic               ext_ready_q;
    logic [31:0]        ext_rd_q;

    assign is_cfg     = i_vector_op & (i_funct3 == 3'b111);
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // Fullness is judged on the count before this cycle's pop. A slot freed in
    // this cycle therefore only becomes usable in the next cycle, which keeps
    // the push decision independent of the backend's ready.
    assign push = (state == IDLE) & i_vpu_valid & ~fifo_full;
    assign pop  = ~fifo_empty & i_cmd_ready;

    assign cmd_in = {i_rs2, i_rs1, i_vs2, i_vs1, i_vd, i_mop, i_vm,
                     i_funct6, i_funct3, i_store_fp_op, i_load_fp_op};

    // ---- FIFO storage: data only, written at the enqueue edge, no reset ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // ---- FIFO pointers and occupancy ----
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_cmd_valid = ~fifo_empty;
    assign o_cmd_data  = mem[rd_ptr];

    // ---- Core handshake FSM with registered ready/rd outputs ----
    // ext_ready_q is high exactly while in RESP. ext_rd_q carries the latched
    // config result during RESP and is zero in every other cycle, so the core
    // never sees a stale result.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            ext_ready_q <= 1'b0;
            ext_rd_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ext_ready_q <= 1'b0;
                    ext_rd_q    <= '0;
                    if (push) begin
                        if (is_cfg) begin
                            state <= WAIT_RES;
                        end else begin
                            state       <= RESP;
                            ext_ready_q <= 1'b1;
                        end
                    end
                end
                WAIT_RES: begin
                    if (i_res_valid) begin
                        state       <= RESP;
                        ext_ready_q <= 1'b1;
                        ext_rd_q    <= i_res_data;
                    end
                end
                RESP: begin
                    state       <= GUARD;
                    ext_ready_q <= 1'b0;
                    ext_rd_q    <= '0;
                end
                GUARD: begin
                    // The core still holds valid in the cycle after ready.
                    // Skipping one cycle stops that command from being queued
                    // twice.
                    state       <= IDLE;
                    ext_ready_q <= 1'b0;
                    ext_rd_q    <= '0;
                end
                default: begin
                    state       <= IDLE;
                    ext_ready_q <= 1'b0;
                    ext_rd_q    <= '0;
                end
            endcase
        end
    end

    assign o_ext_ready = ext_ready_q;
    assign o_ext_rd    = ext_rd_q;
    assign o_busy      = ~fifo_empty | (state != IDLE);

`ifdef VPU_ISSUE_PERF_EN
    // ---- Performance counters ----
    logic [31:0] perf_issued_q;
    logic [31:0] perf_full_stall_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_issued_q     <= '0;
            perf_full_stall_q <= '0;
        end else begin
            if (push) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if ((state == IDLE) && i_vpu_valid && fifo_full) begin
                perf_full_stall_q <= perf_full_stall_q + 32'd1;
            end
        end
    end

    assign o_perf_issued     = perf_issued_q;
    assign o_perf_full_stall = perf_full_stall_q;
`endif

endmodule

// File: tb/tb_serv_vpu_issue_q.sv
// ---------------------------------------------------------------------------
// tb_serv_vpu_issue_q
//
// Directed self-checking bench for serv_vpu_issue_q with DEPTH=4.
// Inputs change 1 time unit after the rising edge. Outputs are sampled at that
// same point, so they show the state produced by the edge that just occurred.
// ---------------------------------------------------------------------------
module tb_serv_vpu_issue_q;

    logic        clk;
    logic        i_rst_n;
    logic        i_vpu_valid;
    logic        i_vector_op;
    logic        i_load_fp_op;
    logic        i_store_fp_op;
    logic [2:0]  i_funct3;
    logic [5:0]  i_funct6;
    logic        i_vm;
    logic [1:0]  i_mop;
    logic [4:0]  i_vd;
    logic [4:0]  i_vs1;
    logic [4:0]  i_vs2;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        o_ext_ready;
    logic [31:0] o_ext_rd;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic [92:0] o_cmd_data;
    logic        i_res_valid;
    logic [31:0] i_res_data;
    logic        o_busy;
`ifdef VPU_ISSUE_PERF_EN
    logic [31:0] o_perf_issued;
    logic [31:0] o_perf_full_stall;
`endif

    int vectors;
    int miscompares;

    serv_vpu_issue_q #(.DEPTH(4)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_vpu_valid   (i_vpu_valid),
        .i_vector_op   (i_vector_op),
        .i_load_fp_op  (i_load_fp_op),
        .i_store_fp_op (i_store_fp_op),
        .i_funct3      (i_funct3),
        .i_funct6      (i_funct6),
        .i_vm          (i_vm),
        .i_mop         (i_mop),
        .i_vd          (i_vd),
        .i_vs1         (i_vs1),
        .i_vs2         (i_vs2),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .o_ext_ready   (o_ext_ready),
        .o_ext_rd      (o_ext_rd),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_cmd_data    (o_cmd_data),
        .i_res_valid   (i_res_valid),
        .i_res_data    (i_res_data),
        .o_busy        (o_busy)
`ifdef VPU_ISSUE_PERF_EN
        ,
        .o_perf_issued     (o_perf_issued),
        .o_perf_full_stall (o_perf_full_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sets up a plain (non-config) OP-V command on the input fields.
    task automatic set_op(input logic [4:0] vd, input logic [31:0] rs1);
        i_vector_op   = 1'b1;
        i_load_fp_op  = 1'b0;
        i_store_fp_op = 1'b0;
        i_funct3      = 3'b000;
        i_funct6      = 6'h00;
        i_vm          = 1'b1;
        i_mop         = 2'd0;
        i_vd          = vd;
        i_vs1         = 5'd0;
        i_vs2         = 5'd0;
        i_rs1         = rs1;
        i_rs2         = 32'd0;
    endtask

    // Core model: raise valid, wait for ready, check latency and rd==0, drop
    // valid, then advance into the GUARD cycle.
    task automatic issue(input logic [4:0] vd, input logic [31:0] rs1, input int exp_lat);
        int n;
        bit got;
        set_op(vd, rs1);
        i_vpu_valid = 1'b1;
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            n = i;
            if (o_ext_ready === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL issue_timeout vd=%0d: no o_ext_ready within 20 cycles", vd);
        end else if (n != exp_lat) begin
            miscompares++;
            $display("FAIL issue_latency vd=%0d: got %0d cycles, expected %0d", vd, n, exp_lat);
        end
        vectors++;
        if (o_ext_rd !== 32'd0) begin
            miscompares++;
            $display("FAIL issue_rd vd=%0d: got %0h, expected 0", vd, o_ext_rd);
        end
        i_vpu_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        tick();
        tick();
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0", o_ext_ready); end
        vectors++; if (o_ext_rd !== 32'd0) begin miscompares++; $display("FAIL reset_rd: got %0h, expected 0", o_ext_rd); end
        vectors++; if (o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_valid: got %b, expected 0", o_cmd_valid); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
        i_rst_n = 1'b1;
        tick();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy_after_release: got %b, expected 0", o_busy); end
    endtask

    task automatic test_full();
        i_cmd_ready = 1'b0;
        issue(5'd0, 32'd100, 1);
        issue(5'd1, 32'd101, 2);
        issue(5'd2, 32'd102, 2);
        issue(5'd3, 32'd103, 2);
        // Fifth command, presented during GUARD, must stall on a full FIFO.
        set_op(5'd4, 32'd104);
        i_vpu_valid = 1'b1;
        tick();  // GUARD -> IDLE
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL full_stall_a: got ready %b, expected 0", o_ext_ready); end
        tick();  // stall edge 1
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL full_stall_b: got ready %b, expected 0", o_ext_ready); end
        tick();  // stall edge 2
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL full_stall_c: got ready %b, expected 0", o_ext_ready); end
        vectors++; if (o_cmd_data[18:14] !== 5'd0) begin miscompares++; $display("FAIL full_head0_vd: got %0d, expected 0", o_cmd_data[18:14]); end
        i_cmd_ready = 1'b1;
        tick();  // stall edge 3 with pop; the freed slot is not usable yet
        i_cmd_ready = 1'b0;
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_no_push: got ready %b, expected 0", o_ext_ready); end
        vectors++; if (o_cmd_data[18:14] !== 5'd1) begin miscompares++; $display("FAIL full_head1_vd: got %0d, expected 1", o_cmd_data[18:14]); end
        tick();  // fifth command enqueued
        vectors++; if (o_ext_ready !== 1'b1) begin miscompares++; $display("FAIL full_fifth_ready: got %b, expected 1", o_ext_ready); end
`ifdef VPU_ISSUE_PERF_EN
        vectors++; if (o_perf_issued !== 32'd5) begin miscompares++; $display("FAIL perf_issued: got %0d, expected 5", o_perf_issued); end
        vectors++; if (o_perf_full_stall !== 32'd3) begin miscompares++; $display("FAIL perf_full_stall: got %0d, expected 3", o_perf_full_stall); end
`endif
        i_vpu_valid = 1'b0;
        tick();  // GUARD
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (o_cmd_valid !== 1'b1 || o_cmd_data[18:14] !== 5'(k) || o_cmd_data[60:29] !== 32'(100 + k)) begin
                miscompares++;
                $display("FAIL full_order_%0d: got valid=%b vd=%0d rs1=%0d, expected valid=1 vd=%0d rs1=%0d",
                         k, o_cmd_valid, o_cmd_data[18:14], o_cmd_data[60:29], k, 100 + k);
            end
            i_cmd_ready = 1'b1;
            tick();
            i_cmd_ready = 1'b0;
        end
        vectors++; if (o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL full_drained: got %b, expected 0", o_cmd_valid); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL full_busy: got %b, expected 0", o_busy); end
    endtask

    task automatic test_single();
        logic [92:0] exp;
        exp = {32'h0000_2222, 32'h0000_1111, 5'd2, 5'd1, 5'd3, 2'd0, 1'b1, 6'h00, 3'b000, 1'b0, 1'b0};
        i_cmd_ready = 1'b1;
        set_op(5'd3, 32'h1111);
        i_vs1 = 5'd1;
        i_vs2 = 5'd2;
        i_rs2 = 32'h2222;
        i_vpu_valid = 1'b1;
        tick();  // cycle N+1
        vectors++; if (o_ext_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b, expected 1", o_ext_ready); end
        vectors++; if (o_ext_rd !== 32'd0) begin miscompares++; $display("FAIL single_rd: got %0h, expected 0", o_ext_rd); end
        vectors++; if (o_cmd_valid !== 1'b1) begin miscompares++; $display("FAIL single_cmd_valid: got %b, expected 1", o_cmd_valid); end
        vectors++; if (o_cmd_data !== exp) begin miscompares++; $display("FAIL single_cmd_data: got %h, expected %h", o_cmd_data, exp); end
        vectors++; if (o_cmd_data[1:0] !== 2'b00) begin miscompares++; $display("FAIL single_load_store: got %b, expected 00", o_cmd_data[1:0]); end
        i_vpu_valid = 1'b0;
        i_vd = 5'd9;  // later input changes must not disturb the queue
        tick();  // GUARD, head popped
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_pulse: got %b, expected 0", o_ext_ready); end
        vectors++; if (o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL single_popped: got %b, expected 0", o_cmd_valid); end
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_guard: got %b, expected 1", o_busy); end
        tick();  // IDLE
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %b, expected 0", o_busy); end
        i_cmd_ready = 1'b0;
    endtask

    task automatic test_hold_valid();
        i_cmd_ready = 1'b0;
        set_op(5'd7, 32'd7);
        i_vpu_valid = 1'b1;
        tick();  // RESP
        vectors++; if (o_ext_ready !== 1'b1) begin miscompares++; $display("FAIL hold_ready: got %b, expected 1", o_ext_ready); end
        tick();  // GUARD, valid still held
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL hold_guard_ready: got %b, expected 0", o_ext_ready); end
        tick();  // IDLE, valid still held through GUARD edge
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL hold_idle_ready: got %b, expected 0", o_ext_ready); end
        i_vpu_valid = 1'b0;
        vectors++; if (o_cmd_valid !== 1'b1) begin miscompares++; $display("FAIL hold_queued: got %b, expected 1", o_cmd_valid); end
        i_cmd_ready = 1'b1;
        tick();
        i_cmd_ready = 1'b0;
        vectors++; if (o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL hold_single_entry: got %b, expected 0", o_cmd_valid); end
    endtask

    task automatic test_cfg();
        i_cmd_ready = 1'b1;
        set_op(5'd0, 32'd16);
        i_funct3 = 3'b111;
        i_vpu_valid = 1'b1;
        tick();  // WAIT_RES cycle 1
        vectors++; if (o_ext_ready !== 1'b0) begin miscompares++; $display("FAIL cfg_no_early_ready: got %b, expected 0", o_ext_ready); end
        vectors++; if (o_cmd_data[60:29] !== 32'd16 || o_cmd_data[4:2] !== 3'b111) begin miscompares++; $display("FAIL cfg_cmd_fields: got rs1=%0d funct3=%0d, expected 16/7", o_cmd_data[60:29], o_cmd_data[4:2]); end
        for (int i = 2; i <= 6; i++) begin
            tick();
            vectors++;
            if (o_ext_ready !== 1'b0 || o_ext_rd !== 32'd0 || o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL cfg_wait_%0d: got ready=%b rd=%0h busy=%b, expected 0/0/1", i, o_ext_ready, o_ext_rd, o_busy);
            end
        end
        i_res_valid = 1'b1;
        i_res_data  = 32'd8;
        tick();  // RESP
        i_res_valid = 1'b0;
        i_res_data  = 32'd0;
        vectors++; if (o_ext_ready !== 1'b1) begin miscompares++; $display("FAIL cfg_ready: got %b, expected 1", o_ext_ready); end
        vectors++; if (o_ext_rd !== 32'd8) begin miscompares++; $display("FAIL cfg_rd: got %0d, expected 8", o_ext_rd); end
        i_vpu_valid = 1'b0;
        tick();  // GUARD
        vectors++; if (o_ext_rd !== 32'd0) begin miscompares++; $display("FAIL cfg_rd_cleared: got %0h, expected 0", o_ext_rd); end
        tick();  // IDLE
        // A stray result strobe while idle must be ignored.
        i_res_valid = 1'b1;
        i_res_data  = 32'd99;
        tick();
        i_res_valid = 1'b0;
        i_res_data  = 32'd0;
        vectors++; if (o_ext_ready !== 1'b0 || o_ext_rd !== 32'd0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL cfg_stray: got ready=%b rd=%0h busy=%b, expected 0/0/0", o_ext_ready, o_ext_rd, o_busy); end
        issue(5'd5, 32'd5, 1);  // non-cfg result after stray strobe stays 0
        tick();  // IDLE
        i_cmd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit saw_ready;
        bit saw_valid;
        i_cmd_ready = 1'b0;
        issue(5'd10, 32'd10, 1);
        issue(5'd11, 32'd11, 2);
        set_op(5'd12, 32'd12);
        i_funct3 = 3'b111;
        i_vpu_valid = 1'b1;
        tick();  // GUARD -> IDLE
        tick();  // cfg enqueued, WAIT_RES
        vectors++; if (o_busy !== 1'b1 || o_cmd_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre: got busy=%b cmd_valid=%b, expected 1/1", o_busy, o_cmd_valid); end
        #2 i_rst_n = 1'b0;
        #1;
        vectors++; if (o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_cmd_valid: got %b, expected 0", o_cmd_valid); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b, expected 0", o_busy); end
        vectors++; if (o_ext_ready !== 1'b0 || o_ext_rd !== 32'd0) begin miscompares++; $display("FAIL rstmid_ext: got ready=%b rd=%0h, expected 0/0", o_ext_ready, o_ext_rd); end
        i_vpu_valid = 1'b0;
        i_res_valid = 1'b1;
        i_res_data  = 32'd5;
        tick();
        i_res_valid = 1'b0;
        i_res_data  = 32'd0;
        tick();
        i_rst_n = 1'b1;
        saw_ready = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_ext_ready !== 1'b0) saw_ready = 1'b1;
            if (o_cmd_valid !== 1'b0) saw_valid = 1'b1;
        end
        vectors++; if (saw_ready) begin miscompares++; $display("FAIL rstmid_no_ready: got ready pulse, expected none"); end
        vectors++; if (saw_valid) begin miscompares++; $display("FAIL rstmid_no_cmd: got cmd_valid, expected none"); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        i_rst_n       = 1'b1;
        i_vpu_valid   = 1'b0;
        i_vector_op   = 1'b0;
        i_load_fp_op  = 1'b0;
        i_store_fp_op = 1'b0;
        i_funct3      = 3'b000;
        i_funct6      = 6'h00;
        i_vm          = 1'b0;
        i_mop         = 2'd0;
        i_vd          = 5'd0;
        i_vs1         = 5'd0;
        i_vs2         = 5'd0;
        i_rs1         = 32'd0;
        i_rs2         = 32'd0;
        i_cmd_ready   = 1'b0;
        i_res_valid   = 1'b0;
        i_res_data    = 32'd0;

        test_reset();
        test_full();
        test_single();
        test_hold_valid();
        test_cfg();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
